// File: rtl/ab_index_sequencer_if.sv
// Index-pair stream bus for the sequence-A/B symbol memories.
// Master drives valid and indices; slave returns ready.
interface ab_index_sequencer_if #(
    parameter int BitAddr = 8
);
    logic               out_valid;
    logic               out_ready;
    logic [BitAddr:0]   index_a;
    logic [BitAddr:0]   index_b;

    modport master (
        output out_valid,
        output index_a,
        output index_b,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  index_a,
        input  index_b,
        output out_ready
    );
endinterface

// File: rtl/ab_index_sequencer.sv
// Needleman-Wunsch A/B index sequencer: row-major fill scan and traceback walk.
// Optional macro TRACE_CHECK_EN: sticky err flag on illegal traceback moves.
module ab_index_sequencer #(
    parameter int N       = 128,
    parameter int M       = 128,
    parameter int BitAddr = $clog2(((N > M) ? N : M) + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_fill,
    input  logic                        start_trace,
    ab_index_sequencer_if.master        idx_bus,
    input  logic                        move_valid,
    input  logic [1:0]                  move,
    output logic                        busy,
    output logic                        fill_done,
    output logic                        trace_done,
    output logic                        err
);

    localparam int W = BitAddr + 1;
    localparam logic [BitAddr:0] LAST_A = W'(N);
    localparam logic [BitAddr:0] LAST_B = W'(M);
    localparam logic [BitAddr:0] ONE    = W'(1);
    localparam logic [BitAddr:0] ZERO   = '0;

    localparam logic [1:0] MV_DIAG = 2'b00;
    localparam logic [1:0] MV_UP   = 2'b01;
    localparam logic [1:0] MV_LEFT = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_FILL_DONE,
        S_TRACE
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [BitAddr:0] idx_a;
    logic [BitAddr:0] idx_b;
    logic [BitAddr:0] idx_a_d;
    logic [BitAddr:0] idx_b_d;
    logic             valid_q;
    logic             valid_d;
    logic             fill_done_q;
    logic             trace_done_q;
    logic             trace_done_d;
    logic             beat;
    logic             move_fire;
    logic             move_ok;
    logic [BitAddr:0] mv_a;
    logic [BitAddr:0] mv_b;

`ifdef TRACE_CHECK_EN
    logic             err_q;
    logic             err_d;
`endif

    assign beat      = valid_q && idx_bus.out_ready;
    assign move_fire = beat && move_valid;

    // Decode a traceback move into its target indices and legality.
    always_comb begin
        move_ok = 1'b0;
        mv_a    = idx_a;
        mv_b    = idx_b;
        case (move)
            MV_DIAG: begin
                if (idx_a != ZERO && idx_b != ZERO) begin
                    move_ok = 1'b1;
                    mv_a    = idx_a - ONE;
                    mv_b    = idx_b - ONE;
                end
            end
            MV_UP: begin
                if (idx_a != ZERO) begin
                    move_ok = 1'b1;
                    mv_a    = idx_a - ONE;
                end
            end
            MV_LEFT: begin
                if (idx_b != ZERO) begin
                    move_ok = 1'b1;
                    mv_b    = idx_b - ONE;
                end
            end
            default: begin
                move_ok = 1'b0;
            end
        endcase
    end

    // Next-state and next-output logic for the sequencer FSM.
    always_comb begin
        state_d      = state;
        idx_a_d      = idx_a;
        idx_b_d      = idx_b;
        valid_d      = valid_q;
        trace_done_d = 1'b0;
`ifdef TRACE_CHECK_EN
        err_d        = err_q;
`endif
        case (state)
            S_IDLE, S_FILL_DONE: begin
                idx_a_d = ZERO;
                idx_b_d = ZERO;
                valid_d = 1'b0;
                if (start_fill) begin
                    state_d = S_FILL;
                    idx_a_d = ONE;
                    idx_b_d = ONE;
                    valid_d = 1'b1;
                end else if (start_trace) begin
                    state_d = S_TRACE;
                    idx_a_d = LAST_A;
                    idx_b_d = LAST_B;
                    valid_d = 1'b1;
                end
            end
            S_FILL: begin
                if (beat) begin
                    if (idx_b < LAST_B) begin
                        idx_b_d = idx_b + ONE;
                    end else if (idx_a < LAST_A) begin
                        idx_a_d = idx_a + ONE;
                        idx_b_d = ONE;
                    end else begin
                        state_d = S_FILL_DONE;
                        idx_a_d = ZERO;
                        idx_b_d = ZERO;
                        valid_d = 1'b0;
                    end
                end
            end
            S_TRACE: begin
                if (move_fire) begin
                    if (move_ok) begin
                        idx_a_d = mv_a;
                        idx_b_d = mv_b;
                        if (mv_a == ZERO && mv_b == ZERO) begin
                            state_d      = S_IDLE;
                            valid_d      = 1'b0;
                            trace_done_d = 1'b1;
                        end
                    end else begin
`ifdef TRACE_CHECK_EN
                        err_d = 1'b1;
`endif
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_a_d = ZERO;
                idx_b_d = ZERO;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any phase at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            idx_a        <= ZERO;
            idx_b        <= ZERO;
            valid_q      <= 1'b0;
            fill_done_q  <= 1'b0;
            trace_done_q <= 1'b0;
        end else begin
            state        <= state_d;
            idx_a        <= idx_a_d;
            idx_b        <= idx_b_d;
            valid_q      <= valid_d;
            fill_done_q  <= (state_d == S_FILL_DONE);
            trace_done_q <= trace_done_d;
        end
    end

`ifdef TRACE_CHECK_EN
    // Sticky illegal-move flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign idx_bus.out_valid = valid_q;
    assign idx_bus.index_a   = idx_a;
    assign idx_bus.index_b   = idx_b;
    assign busy              = (state == S_FILL) || (state == S_TRACE);
    assign fill_done         = fill_done_q;
    assign trace_done        = trace_done_q;

endmodule

// File: tb/tb_ab_index_sequencer.sv
// Directed bench for ab_index_sequencer: 2x3, 3x3 and 1x2 instances.
// Shared stimulus; each table row names the instance it checks.
module tb_ab_index_sequencer;

`ifdef TRACE_CHECK_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    localparam logic [1:0] DIAG = 2'b00;
    localparam logic [1:0] UP   = 2'b01;
    localparam logic [1:0] LEFT = 2'b10;
    localparam logic [1:0] ILL  = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic       sf;
    logic       st;
    logic       rdy;
    logic       mvv;
    logic [1:0] mv;

    logic busy0, fd0, td0, err0;
    logic busy1, fd1, td1, err1;
    logic busy2, fd2, td2, err2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ab_index_sequencer_if #(.BitAddr(2)) if0 ();
    ab_index_sequencer_if #(.BitAddr(2)) if1 ();
    ab_index_sequencer_if #(.BitAddr(2)) if2 ();

    assign if0.out_ready = rdy;
    assign if1.out_ready = rdy;
    assign if2.out_ready = rdy;

    ab_index_sequencer #(.N(2), .M(3)) u0 (
        .clk(clk), .rst(rst), .start_fill(sf), .start_trace(st),
        .idx_bus(if0), .move_valid(mvv), .move(mv),
        .busy(busy0), .fill_done(fd0), .trace_done(td0), .err(err0)
    );

    ab_index_sequencer #(.N(3), .M(3)) u1 (
        .clk(clk), .rst(rst), .start_fill(sf), .start_trace(st),
        .idx_bus(if1), .move_valid(mvv), .move(mv),
        .busy(busy1), .fill_done(fd1), .trace_done(td1), .err(err1)
    );

    ab_index_sequencer #(.N(1), .M(2)) u2 (
        .clk(clk), .rst(rst), .start_fill(sf), .start_trace(st),
        .idx_bus(if2), .move_valid(mvv), .move(mv),
        .busy(busy2), .fill_done(fd2), .trace_done(td2), .err(err2)
    );

    // observed bundle: {valid, a[2:0], b[2:0], fill_done, busy, trace_done, err}
    logic [10:0] obs [3];
    assign obs[0] = {if0.out_valid, if0.index_a, if0.index_b, fd0, busy0, td0, err0};
    assign obs[1] = {if1.out_valid, if1.index_a, if1.index_b, fd1, busy1, td1, err1};
    assign obs[2] = {if2.out_valid, if2.index_a, if2.index_b, fd2, busy2, td2, err2};

    typedef struct {
        int         d;
        bit         rb;
        bit         sf;
        bit         st;
        bit         rdy;
        bit         mvv;
        logic [1:0] mv;
        bit         v;
        int         a;
        int         b;
        bit         fd;
        bit         bz;
        bit         td;
        bit         er;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int d, bit rb, bit f, bit t, bit r, bit mvl,
                                logic [1:0] m, bit v, int a, int b,
                                bit fd, bit bz, bit td, bit er);
        vec_t x;
        x.d = d; x.rb = rb; x.sf = f; x.st = t; x.rdy = r;
        x.mvv = mvl; x.mv = m; x.v = v; x.a = a; x.b = b;
        x.fd = fd; x.bz = bz; x.td = td; x.er = er;
        return x;
    endfunction

    function automatic logic [10:0] pack(bit v, int a, int b, bit fd,
                                         bit bz, bit td, bit er);
        logic [2:0] aa;
        logic [2:0] bb;
        aa = 3'(a);
        bb = 3'(b);
        return {v, aa, bb, fd, bz, td, er};
    endfunction

    task automatic check(string name, logic [10:0] got, logic [10:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b required=%b", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; sf = 0; st = 0; rdy = 0; mvv = 0; mv = 2'b00;

        // 2x3 fill, ready held high; stray move/start_trace ignored in FILL
        tbl.push_back(mk(0,1,1,0,1,0,DIAG, 1,1,1,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,1,0,DIAG, 1,1,2,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,1,1,DIAG, 1,1,3,0,1,0,0));
        tbl.push_back(mk(0,0,0,1,1,0,DIAG, 1,2,1,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,1,0,DIAG, 1,2,2,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,1,0,DIAG, 1,2,3,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,1,0,DIAG, 0,0,0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,1,1,DIAG, 0,0,0,1,0,0,0));
        // restart from FILL_DONE with ready toggling
        tbl.push_back(mk(0,0,1,0,0,0,DIAG, 1,1,1,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,1,0,DIAG, 1,1,2,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,DIAG, 1,1,2,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,DIAG, 1,1,2,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,1,0,DIAG, 1,1,3,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,1,0,DIAG, 1,2,1,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,DIAG, 1,2,1,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,1,0,DIAG, 1,2,2,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,1,0,DIAG, 1,2,3,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,1,0,DIAG, 0,0,0,1,0,0,0));
        // traceback started from FILL_DONE
        tbl.push_back(mk(0,0,0,1,1,0,DIAG, 1,2,3,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,1,0,LEFT, 1,2,3,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,LEFT, 1,2,3,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,1,1,LEFT, 1,2,2,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,1,1,UP,   1,1,2,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,1,1,DIAG, 1,0,1,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,1,1,LEFT, 0,0,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,1,0,DIAG, 0,0,0,0,0,0,0));
        // simultaneous starts from IDLE: fill wins
        tbl.push_back(mk(0,1,1,1,1,0,DIAG, 1,1,1,0,1,0,0));
        // 3x3 traceback DIAG, UP, LEFT, DIAG; start_fill ignored in TRACE
        tbl.push_back(mk(1,1,0,1,1,0,DIAG, 1,3,3,0,1,0,0));
        tbl.push_back(mk(1,0,0,0,1,1,DIAG, 1,2,2,0,1,0,0));
        tbl.push_back(mk(1,0,1,0,1,1,UP,   1,1,2,0,1,0,0));
        tbl.push_back(mk(1,0,0,0,1,1,LEFT, 1,1,1,0,1,0,0));
        tbl.push_back(mk(1,0,0,0,1,1,DIAG, 0,0,0,0,0,1,0));
        tbl.push_back(mk(1,0,0,0,1,0,DIAG, 0,0,0,0,0,0,0));
        // 1x2 traceback with illegal moves
        tbl.push_back(mk(2,1,0,1,1,0,DIAG, 1,1,2,0,1,0,0));
        tbl.push_back(mk(2,0,0,0,1,1,DIAG, 1,0,1,0,1,0,0));
        tbl.push_back(mk(2,0,0,0,1,1,UP,   1,0,1,0,1,0,CK));
        tbl.push_back(mk(2,0,0,0,1,1,ILL,  1,0,1,0,1,0,CK));
        tbl.push_back(mk(2,0,0,0,1,1,DIAG, 1,0,1,0,1,0,CK));
        tbl.push_back(mk(2,0,0,0,1,1,LEFT, 0,0,0,0,0,1,CK));
        tbl.push_back(mk(2,0,0,0,1,0,DIAG, 0,0,0,0,0,0,CK));
        tbl.push_back(mk(2,1,0,0,0,0,DIAG, 0,0,0,0,0,0,0));
        // 1x2 fill
        tbl.push_back(mk(2,0,1,0,1,0,DIAG, 1,1,1,0,1,0,0));
        tbl.push_back(mk(2,0,0,0,1,0,DIAG, 1,1,2,0,1,0,0));
        tbl.push_back(mk(2,0,0,0,1,0,DIAG, 0,0,0,1,0,0,0));

        #12;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_dut%0d", k), obs[k], 11'b0);
        end
        @(negedge clk);
        rst = 1'b1;
        step();

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rb) pulse_reset();
            sf  = tbl[i].sf;
            st  = tbl[i].st;
            rdy = tbl[i].rdy;
            mvv = tbl[i].mvv;
            mv  = tbl[i].mv;
            step();
            check($sformatf("row%0d_dut%0d", i, tbl[i].d), obs[tbl[i].d],
                  pack(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].fd,
                       tbl[i].bz, tbl[i].td, tbl[i].er));
        end

        // asynchronous reset in the middle of a fill at (1,2)
        sf = 0; st = 0; mvv = 0; rdy = 1;
        pulse_reset();
        sf = 1;
        step();
        check("arst_fill_11", obs[0], pack(1, 1, 1, 0, 1, 0, 0));
        sf = 0;
        step();
        check("arst_fill_12", obs[0], pack(1, 1, 2, 0, 1, 0, 0));
        #2;
        rst = 1'b0;
        #1;
        check("arst_abort", obs[0], 11'b0);
        #1;
        rst = 1'b1;
        sf = 1;
        step();
        check("arst_restart_11", obs[0], pack(1, 1, 1, 0, 1, 0, 0));
        sf = 0;
        step();
        check("arst_restart_12", obs[0], pack(1, 1, 2, 0, 1, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
